// File: rtl/cam_pkg.sv
// Purpose: shared types and constants for the CAM refill controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, statistics counter width, saturating increment helper.
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS,
        FILL,
        RESP
    } cam_state_t;

    localparam int STATS_W = 16;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/cam_victim_sel.sv
// Purpose: pick the CAM entry to overwrite on a refill.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
// Ports: valid_map (one shadow valid bit per entry), rr_ptr (round-robin
//        pointer) -> victim (entry index), all_valid (no free entry left).
module cam_victim_sel
    import cam_pkg::*;
#(
    parameter int WORDS     = 8,
    parameter int ADDR_LEFT = $clog2(WORDS) - 1
) (
    input  logic [WORDS-1:0]   valid_map,
    input  logic [ADDR_LEFT:0] rr_ptr,
    output logic [ADDR_LEFT:0] victim,
    output logic               all_valid
);

    localparam int AW = ADDR_LEFT + 1;

    logic [ADDR_LEFT:0] first_free;

    // Scan from the top down so the last assignment wins with the lowest
    // free index.
    always_comb begin
        first_free = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (!valid_map[i]) begin
                first_free = AW'(i);
            end
        end
    end

    assign all_valid = &valid_map;
    assign victim    = all_valid ? rr_ptr : first_free;

endmodule

// File: rtl/cam_fill_ctrl.sv
// Purpose: CAM lookup front end that refills misses from memory and writes them back.
// Latency: hit responds 2 cycles after the request cycle; miss adds memory wait + 1 fill cycle.
// Backpressure: req_ready only in IDLE, one request in flight; requests elsewhere are dropped.
// Ports: clk/rst (async active-high); req_* lookup request; resp_* one-cycle
//        response; cam_* CAM read/write side; mem_* refill request/ack.
// Optional: define CAM_FILL_CTRL_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module cam_fill_ctrl
    import cam_pkg::*;
#(
    parameter int WORDS     = 8,
    parameter int BITS      = 8,
    parameter int TAG_SZ    = 8,
    parameter int ADDR_LEFT = $clog2(WORDS) - 1
) (
    input  logic                 clk,
    input  logic                 rst,
    // request
    input  logic                 req_valid,
    input  logic [TAG_SZ-1:0]    req_tag,
    output logic                 req_ready,
    // response
    output logic                 resp_valid,
    output logic [BITS-1:0]      resp_data,
    output logic                 resp_hit,
    // CAM side
    output logic                 cam_read,
    output logic [TAG_SZ-1:0]    cam_check_tag,
    input  logic                 cam_found_it,
    input  logic [BITS-1:0]      cam_data,
    output logic                 cam_write_,
    output logic [ADDR_LEFT:0]   cam_w_addr,
    output logic [BITS-1:0]      cam_wdata,
    output logic [TAG_SZ-1:0]    cam_new_tag,
    output logic                 cam_new_valid,
    // memory refill
    output logic                 mem_req,
    output logic [TAG_SZ-1:0]    mem_tag,
    input  logic                 mem_ack,
    input  logic [BITS-1:0]      mem_rdata
`ifdef CAM_FILL_CTRL_STATS_EN
    ,
    output logic [STATS_W-1:0]   hit_cnt,
    output logic [STATS_W-1:0]   miss_cnt
`endif
);

    localparam int                AW       = ADDR_LEFT + 1;
    localparam logic [ADDR_LEFT:0] LAST_IDX = AW'(WORDS - 1);

    cam_state_t          state, state_nxt;
    logic [TAG_SZ-1:0]   tag_q;
    logic [BITS-1:0]     data_q;
    logic                hit_q;
    logic [ADDR_LEFT:0]  rr_ptr;
    logic [WORDS-1:0]    valid_map;

    logic [ADDR_LEFT:0]  victim;
    logic                all_valid;

    cam_victim_sel #(
        .WORDS     (WORDS),
        .ADDR_LEFT (ADDR_LEFT)
    ) u_victim_sel (
        .valid_map (valid_map),
        .rr_ptr    (rr_ptr),
        .victim    (victim),
        .all_valid (all_valid)
    );

    // State register plus the datapath registers that move with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tag_q     <= '0;
            data_q    <= '0;
            hit_q     <= 1'b0;
            rr_ptr    <= '0;
            valid_map <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tag_q <= req_tag;
                    end
                end
                LOOKUP: begin
                    hit_q <= cam_found_it;
                    if (cam_found_it) begin
                        data_q <= cam_data;
                    end
                end
                MISS: begin
                    if (mem_ack) begin
                        data_q <= mem_rdata;
                    end
                end
                FILL: begin
                    valid_map[victim] <= 1'b1;
                    // The pointer only moves when it actually chose the victim,
                    // so free-slot fills never disturb the rotation.
                    if (all_valid) begin
                        rr_ptr <= (rr_ptr == LAST_IDX) ? '0 : rr_ptr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and Moore outputs; everything not named in a state stays 0.
    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_data     = '0;
        resp_hit      = 1'b0;
        cam_read      = 1'b0;
        cam_check_tag = '0;
        cam_write_    = 1'b0;
        cam_w_addr    = '0;
        cam_wdata     = '0;
        cam_new_tag   = '0;
        cam_new_valid = 1'b0;
        mem_req       = 1'b0;
        mem_tag       = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                cam_read      = 1'b1;
                cam_check_tag = tag_q;
                state_nxt     = cam_found_it ? RESP : MISS;
            end
            MISS: begin
                mem_req = 1'b1;
                mem_tag = tag_q;
                if (mem_ack) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                cam_write_    = 1'b1;
                cam_w_addr    = victim;
                cam_wdata     = data_q;
                cam_new_tag   = tag_q;
                cam_new_valid = 1'b1;
                state_nxt     = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_data  = data_q;
                resp_hit   = hit_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef CAM_FILL_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == RESP) begin
            if (hit_q) begin
                hit_cnt <= sat_inc(hit_cnt);
            end else begin
                miss_cnt <= sat_inc(miss_cnt);
            end
        end
    end
`endif

endmodule

// File: doc/cam_fill_ctrl.md
CAM_FILL_CTRL -- requirements
Module: cam_fill_ctrl

Interface
REQ-001 SHALL have parameters: WORDS, default 8, number of CAM entries; BITS, default 8, data width; TAG_SZ, default 8, tag width; ADDR_LEFT, default $clog2(WORDS)-1, entry-index MSB.
REQ-002 SHALL have ports: clk  in  1  system clock; rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have request ports: req_valid  in  1  lookup request; req_tag  in  TAG_SZ  tag to look up; req_ready  out  1  controller can accept.
REQ-004 SHALL have response ports: resp_valid  out  1  one-cycle response strobe; resp_data  out  BITS  returned data; resp_hit  out  1  1=served from CAM, 0=served after refill.
REQ-005 SHALL have CAM-side ports: cam_read  out  1; cam_check_tag  out  TAG_SZ; cam_found_it  in  1; cam_data  in  BITS; cam_write_  out  1  write strobe; cam_w_addr  out  ADDR_LEFT+1; cam_wdata  out  BITS; cam_new_tag  out  TAG_SZ; cam_new_valid  out  1.
REQ-006 SHALL have memory ports: mem_req  out  1  refill request, held until ack; mem_tag  out  TAG_SZ; mem_ack  in  1  one-cycle data-valid; mem_rdata  in  BITS.

Function
REQ-007 SHALL implement FSM states IDLE, LOOKUP, MISS, FILL, RESP.
REQ-008 IDLE: req_ready=1; req_valid=1 captures req_tag into tag_q, goes to LOOKUP next cycle.
REQ-009 LOOKUP: drive cam_read=1, cam_check_tag=tag_q; sample cam_found_it/cam_data same cycle (CAM combinational); hit -> RESP with resp_hit=1; miss -> MISS.
REQ-010 Hit latency SHALL be exactly 2 cycles from accepting edge to resp_valid.
REQ-011 MISS: mem_req=1, mem_tag=tag_q, held constant until mem_ack=1; on mem_ack capture mem_rdata into data_q, go to FILL.
REQ-012 FILL: exactly one cycle with write strobe active, cam_w_addr=victim, cam_wdata=data_q, cam_new_tag=tag_q, cam_new_valid=1; then RESP with resp_hit=0.
REQ-013 RESP: resp_valid=1 for exactly one cycle with resp_data/resp_hit; return to IDLE; req_ready=0 in all states except IDLE.
REQ-014 Victim selection: lowest-index entry with shadow valid bit 0; if all valid, round-robin pointer rr_ptr.
REQ-015 rr_ptr SHALL increment only when an all-valid victim is used, wrapping WORDS-1 -> 0 (correct for non-power-of-two WORDS).
REQ-016 Shadow valid bitmap (WORDS bits) SHALL set bit victim in FILL; never cleared except by reset.
REQ-017 mem_ack outside MISS SHALL be ignored; req_valid outside IDLE SHALL be ignored (not queued).
REQ-018 Outside FILL: write strobe inactive, cam_new_valid=0; outside LOOKUP: cam_read=0.
REQ-019 Write strobe polarity: cam_write_=1 means write, matching the CAM's write-enable sense.

Reset
REQ-020 rst=1 SHALL asynchronously force: state IDLE, rr_ptr=0, shadow valids=0, tag_q=0, data_q=0.
REQ-021 Output values during/after reset: req_ready=1, resp_valid=0, resp_data=0, resp_hit=0, mem_req=0, cam_read=0, cam_write_=0, all address/data/tag outputs 0.
REQ-022 Reset asserted mid-MISS SHALL drop mem_req immediately; a later mem_ack SHALL be ignored.

Configuration
REQ-023 Macro CAM_FILL_CTRL_STATS_EN defined: add outputs hit_cnt, miss_cnt (16 bits each), incremented in RESP per resp_hit, saturating at 16'hFFFF, cleared by reset.
REQ-024 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-025 Shared package cam_pkg SHALL hold the FSM state enum typedef and the STATS_W=16 constant.
REQ-026 Sub-module cam_victim_sel (combinational: valid bitmap + rr_ptr -> victim index, all_valid flag) SHALL be instantiated once.

Verification
REQ-027 Reset then req tag 8'h3C, mem_ack with 8'hA5 after 3 cycles -> one FILL write at addr 0, tag 8'h3C; resp_valid resp_data=8'hA5 resp_hit=0.
REQ-028 Repeat tag 8'h3C with CAM returning found_it=1 data 8'hA5 -> resp_hit=1, resp_data=8'hA5 exactly 2 cycles after accept; mem_req stays 0.
REQ-029 Nine distinct missing tags 8'h01..8'h09 -> fills addr 0..7 then 9th to addr 0 (rr_ptr 0->1); 10th miss to addr 1.
REQ-030 Assert rst during MISS with mem_req=1 -> mem_req=0 same cycle; subsequent mem_ack -> no FILL, no resp_valid.
REQ-031 req_valid held high during MISS -> req_ready=0, only one response; next request accepted in IDLE.
REQ-032 With CAM_FILL_CTRL_STATS_EN: 1 miss then 2 hits -> miss_cnt=1, hit_cnt=2.
